// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode pipeline: RV32 major opcodes,
// the format encoding presented on the fmt output, and the skid buffer states.
package decode_pkg;

    // Major opcodes recognised by the decoder (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Instruction format as seen on the fmt output; 6 is unused
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_e;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Any opcode outside the table, including a low pair other than 2'b11,
    // cannot be decoded.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e f;
        f = FMT_BAD;
        case (opc)
            OPC_OP:                                     f = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                  f = FMT_S;
            OPC_BRANCH:                                 f = FMT_B;
            OPC_LUI, OPC_AUIPC:                         f = FMT_U;
            OPC_JAL:                                    f = FMT_J;
            default:                                    f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational format classifier and immediate generator. The immediate is
// assembled as a 32-bit value and then sign-extended from its bit 31 to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output fmt_e            fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] imm_o
);

    logic signed [31:0] imm32;

    // Classify by opcode and splice the immediate bits for that format
    always_comb begin
        fmt_o     = opcode_fmt(instr_i[6:0]);
        illegal_o = (fmt_o == FMT_BAD);
        imm32     = '0;
        case (fmt_o)
            FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U:   imm32 = {instr_i[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_o = XLEN'(imm32);
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// Instruction decode stage with a two-entry skid buffer.
// Decode happens combinationally on the input side; the buffer holds fully
// decoded entries so the head entry drives the outputs straight from flops.
// in_ready is registered from the next buffer state, so there is no
// combinational path from out_ready to in_ready.
// Optional feature: define INSTR_DECODE_PERF_COUNT_EN to add saturating
// counters of popped entries (cnt_decoded) and popped illegal entries
// (cnt_illegal).
module instr_decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [XLEN-1:0] out_pc
`ifdef INSTR_DECODE_PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("instr_decode_pipe: XLEN must be 32 or 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("instr_decode_pipe: CNT_W must be at least 1");
    end

    // One decoded buffer entry; raw fields are recovered from instr
    typedef struct packed {
        logic [31:0]     instr;
        fmt_e            fmt;
        logic            illegal;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    skid_state_e     state_q, state_d;
    entry_t          head_q, head_d;
    entry_t          tail_q, tail_d;
    logic            in_ready_q;
    logic            accept;
    logic            pop;
    entry_t          new_entry;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i   (in_instr),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal),
        .imm_o     (dec_imm)
    );

    // Handshakes; nothing is accepted while reset is asserted
    always_comb begin
        accept    = in_valid & in_ready_q & ~reset;
        pop       = (state_q != ST_EMPTY) & out_ready;
        new_entry = '{instr: in_instr, fmt: dec_fmt, illegal: dec_illegal,
                      imm: dec_imm, pc: in_pc};
    end

    // Buffer next-state: head is always the oldest entry, tail the younger
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_d  = new_entry;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    head_d = new_entry;
                end else if (accept) begin
                    state_d = ST_TWO;
                    tail_d  = new_entry;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Buffer registers; reset clears occupancy and zeroes the visible fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign opcode    = head_q.instr[6:0];
    assign rd        = head_q.instr[11:7];
    assign funct3    = head_q.instr[14:12];
    assign rs1       = head_q.instr[19:15];
    assign rs2       = head_q.instr[24:20];
    assign funct7    = head_q.instr[31:25];
    assign imm       = head_q.imm;
    assign fmt       = head_q.fmt;
    assign illegal   = head_q.illegal;
    assign out_pc    = head_q.pc;

`ifdef INSTR_DECODE_PERF_COUNT_EN
    logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d;
    logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;

    // Saturating counts of delivered and delivered-illegal entries
    always_comb begin
        cnt_dec_d = cnt_dec_q;
        cnt_ill_d = cnt_ill_q;
        if (pop && cnt_dec_q != '1) begin
            cnt_dec_d = cnt_dec_q + 1'b1;
        end
        if (pop && head_q.illegal && cnt_ill_q != '1) begin
            cnt_ill_d = cnt_ill_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_dec_q <= '0;
            cnt_ill_q <= '0;
        end else begin
            cnt_dec_q <= cnt_dec_d;
            cnt_ill_q <= cnt_ill_d;
        end
    end

    assign cnt_decoded = cnt_dec_q;
    assign cnt_illegal = cnt_ill_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe. Two instances (XLEN=32 and XLEN=64)
// see identical stimulus; a reference decoder computes each accepted entry,
// and a monitor compares the head entry of both instances every cycle.
module tb_instr_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [6:0]  opc32, f7_32, opc64, f7_64;
    logic [4:0]  rd32, rs1_32, rs2_32, rd64, rs1_64, rs2_64;
    logic [2:0]  f3_32, fmt32, f3_64, fmt64;
    logic [31:0] imm32, pc32;
    logic [63:0] imm64, pc64;
`ifdef INSTR_DECODE_PERF_COUNT_EN
    logic [31:0] cd32, ci32;
    logic [3:0]  cd64, ci64;
    longint      md32, mi32, md64, mi64;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] imm;
    } item_t;

    item_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_decode_pipe #(.XLEN(32), .CNT_W(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(vld32),
        .out_ready(out_ready), .opcode(opc32), .rd(rd32), .funct3(f3_32),
        .rs1(rs1_32), .rs2(rs2_32), .funct7(f7_32), .imm(imm32), .fmt(fmt32),
        .illegal(ill32), .out_pc(pc32)
`ifdef INSTR_DECODE_PERF_COUNT_EN
        , .cnt_decoded(cd32), .cnt_illegal(ci32)
`endif
    );

    instr_decode_pipe #(.XLEN(64), .CNT_W(4)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld64),
        .out_ready(out_ready), .opcode(opc64), .rd(rd64), .funct3(f3_64),
        .rs1(rs1_64), .rs2(rs2_64), .funct7(f7_64), .imm(imm64), .fmt(fmt64),
        .illegal(ill64), .out_pc(pc64)
`ifdef INSTR_DECODE_PERF_COUNT_EN
        , .cnt_decoded(cd64), .cnt_illegal(ci64)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder written from the format/immediate rules
    function automatic item_t model(input logic [31:0] i, input logic [63:0] pc);
        item_t r;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [31:0] u32;
        logic [20:0] j21;
        r.instr = i;
        r.pc    = pc;
        r.ill   = 1'b0;
        r.imm   = 64'd0;
        i12 = i[31:20];
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        u32 = {i[31:12], 12'h000};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (i[6:0])
            7'h33: r.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: begin r.fmt = 3'd1; r.imm = longint'($signed(i12)); end
            7'h23: begin
                i12 = {i[31:25], i[11:7]};
                r.fmt = 3'd2; r.imm = longint'($signed(i12));
            end
            7'h63: begin r.fmt = 3'd3; r.imm = longint'($signed(b13)); end
            7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = longint'($signed(u32)); end
            7'h6F: begin r.fmt = 3'd5; r.imm = longint'($signed(j21)); end
            default: begin r.fmt = 3'd7; r.ill = 1'b1; end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 12))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h67;  4: w[6:0] = 7'h73;  5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h63;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
            9: w[6:0] = 7'h6F;  default: ;
        endcase
        return w;
    endfunction

    // Monitor: occupancy, head entry and counters against the scoreboard
    always @(negedge clk) begin
        int  sz;
        item_t e;
        if (reset) begin
            q.delete();
`ifdef INSTR_DECODE_PERF_COUNT_EN
            md32 = 0; mi32 = 0; md64 = 0; mi64 = 0;
`endif
        end else begin
            sz = q.size();
            chk("in_ready32", 64'(rdy32), 64'(sz < 2));
            chk("in_ready64", 64'(rdy64), 64'(sz < 2));
            chk("out_valid32", 64'(vld32), 64'(sz > 0));
            chk("out_valid64", 64'(vld64), 64'(sz > 0));
`ifdef INSTR_DECODE_PERF_COUNT_EN
            chk("cnt_decoded32", 64'(cd32), 64'(md32));
            chk("cnt_illegal32", 64'(ci32), 64'(mi32));
            chk("cnt_decoded64", 64'(cd64), 64'(md64));
            chk("cnt_illegal64", 64'(ci64), 64'(mi64));
`endif
            if (sz > 0) begin
                e = q[0];
                chk("head32", {opc32, rd32, f3_32, rs1_32, rs2_32, f7_32}, 64'(e.instr[6:0] == 7'h0 ? {e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[31:25]} : {e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[31:25]}));
                chk("head64", {opc64, rd64, f3_64, rs1_64, rs2_64, f7_64}, 64'({e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[31:25]}));
                chk("fmt32", 64'({fmt32, ill32}), 64'({e.fmt, e.ill}));
                chk("fmt64", 64'({fmt64, ill64}), 64'({e.fmt, e.ill}));
                chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
                chk("imm64", imm64, e.imm);
                chk("pc32", 64'(pc32), 64'(e.pc[31:0]));
                chk("pc64", pc64, e.pc);
                if (out_ready) begin
                    void'(q.pop_front());
`ifdef INSTR_DECODE_PERF_COUNT_EN
                    md32++; md64 = (md64 < 15) ? md64 + 1 : 15;
                    if (e.ill) begin
                        mi32++; mi64 = (mi64 < 15) ? mi64 + 1 : 15;
                    end
`endif
                end
            end
            if (in_valid && sz < 2) q.push_back(model(in_instr, in_pc));
        end
    end

    task automatic step(input logic v, input logic [31:0] i, input logic r);
        in_valid  = v;
        in_instr  = i;
        in_pc     = {$urandom, $urandom};
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_fields32"}, {opc32, rd32, f3_32, rs1_32, rs2_32, f7_32, fmt32, ill32}, 64'd0);
        chk({nm, "_fields64"}, {opc64, rd64, f3_64, rs1_64, rs2_64, f7_64, fmt64, ill64}, 64'd0);
        chk({nm, "_imm_pc32"}, {imm32, pc32}, 64'd0);
        chk({nm, "_imm_pc64"}, imm64 | pc64, 64'd0);
        chk({nm, "_vld_rdy"}, {vld32, rdy32, vld64, rdy64}, 64'b0101);
`ifdef INSTR_DECODE_PERF_COUNT_EN
        chk({nm, "_cnt"}, {cd32, ci32}, 64'd0);
        chk({nm, "_cnt64"}, {cd64, ci64}, 64'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero("reset");

        // Directed decode examples, streaming at full rate
        step(1, 32'hFFF10093, 1);
        step(1, 32'hFE000EE3, 1);
        step(1, 32'h0000002E, 1);
        step(1, 32'h800000B7, 1);
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);

        // Backpressure: A and B fill the buffer, C waits until space frees
        step(1, 32'h00A00093, 0);
        step(1, 32'h00B00113, 0);
        chk("in_ready_full", 64'(rdy32), 64'd0);
        step(1, 32'h00C00193, 0);
        step(1, 32'h00C00193, 0);
        step(1, 32'h00C00193, 1);
        step(1, 32'h00C00193, 1);
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);

        // Reset while full, with in_valid held high through the reset cycle
        step(1, 32'h0000002E, 0);
        step(1, 32'h0000002E, 0);
        reset = 1'b1;
        step(1, 32'h00D00213, 1);
        reset = 1'b0;
        chk_zero("midreset");

        // Randomized traffic with stall windows and rare resets
        for (int c = 0; c < 4000; c++) begin
            logic v, r;
            v = ($urandom_range(0, 3) != 0);
            r = ((c / 64) % 3 == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) != 0);
            reset = ($urandom_range(0, 599) == 0);
            step(v, rnd_instr(), r);
        end
        reset = 1'b0;
        repeat (4) step(0, 32'h0, 1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
